mac_array_grp: RTL and testbench

Parametrised next-generation MAC array for the RepVGG accelerator. Computes one output pixel at a time for up to `LANES` output channels in parallel, fusing the 3x3 branch, the 1x1 branch and (optionally) the identity branch. It reads 3x3 input windows from the imap buffer and accumulates over all input channels. Per-lane results are drained one per cycle to the psum accumulator over a valid/ready handshake with backpressure.

---
 rtl/mac_array_grp.sv | 202 ++++++++++++++++++++
 tb/tb_mac_array_grp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_array_grp.sv
// rtl/mac_array_grp.sv - RepVGG MAC array: fused 3x3/1x1/identity per-lane psums, drained over valid/ready.
// Optional identity branch: MAC_ARRAY_GRP_IDENTITY_EN.
module mac_array_grp #(
  parameter int LANES     = 8,
  parameter int DW        = 8,
  parameter int ACC_W     = 32,
  parameter int ACC1_W    = 24,
  parameter int MAX_IN_CH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      conv_start,
  input  logic [7:0]                in_ch,
  input  logic [7:0]                out_ch,
  input  logic [15:0]               map_size,
  output logic                      busy,
  output logic                      conv_done,
  input  logic [31:0]               weight_waddr,
  input  logic [10*DW-1:0]          weight_wdata,
  input  logic                      weight_wen,
  output logic [31:0]               imap_raddr,
  output logic                      imap_ren,
  input  logic [9*DW-1:0]           imap_rdata,
  output logic [8+ACC1_W+ACC_W-1:0] out_data,
  output logic [15:0]               out_pix,
  output logic [7:0]                out_lane,
  output logic                      out_vld,
  input  logic                      out_rdy
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (MAX_IN_CH > 1) ? $clog2(MAX_IN_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [9*DW-1:0] w3 [LANES][MAX_IN_CH];
  logic [DW-1:0]   w1 [LANES][MAX_IN_CH];

  logic [7:0]  in_ch_q, oc_q, oc_clamp, c, rd_c, d1_c, hold_cnt, hold_idx, wr_ch, wr_lane, ident;
  logic [15:0] map_q, p, rd_p, d1_p, hold_pix;
  logic [31:0] addr;
  logic        rd_last, d1_vld, d1_last, d1_ok, cand_last, stall, drain_ok, unused_ok;
  logic signed [ACC_W-1:0]  acc3 [LANES];
  logic signed [ACC_W-1:0]  hold3 [LANES];
  logic signed [ACC_W-1:0]  c3 [LANES];
  logic signed [ACC1_W-1:0] acc1 [LANES];
  logic signed [ACC1_W-1:0] hold1 [LANES];
  logic signed [ACC1_W-1:0] c1 [LANES];

  function automatic logic signed [2*DW-1:0] mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return $signed(a) * $signed(b);
  endfunction

  function automatic logic signed [ACC_W-1:0] dot9(input logic [9*DW-1:0] x, input logic [9*DW-1:0] w);
    logic signed [ACC_W-1:0] s;
    s = '0;
    for (int k = 0; k < 9; k++) s = s + ACC_W'(mul(x[k*DW +: DW], w[k*DW +: DW]));
    return s;
  endfunction

  assign wr_ch     = weight_waddr[15:8];
  assign wr_lane   = weight_waddr[7:0];
  assign unused_ok = &{1'b0, weight_waddr[31:16]};

  always_ff @(posedge clk) begin
    if (weight_wen && !busy && int'(wr_ch) < MAX_IN_CH && int'(wr_lane) < LANES) begin
      w3[wr_lane[LW-1:0]][wr_ch[CW-1:0]] <= weight_wdata[9*DW-1:0];
      w1[wr_lane[LW-1:0]][wr_ch[CW-1:0]] <= weight_wdata[10*DW-1:9*DW];
    end
  end

  // Contribution of the word returning this cycle; channels beyond the weight store add nothing.
  assign d1_ok = int'(d1_c) < MAX_IN_CH;
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      c3[l] = '0;
      c1[l] = '0;
      if (d1_ok) begin
        c3[l] = dot9(imap_rdata, w3[l][d1_c[CW-1:0]]);
        c1[l] = ACC1_W'(mul(imap_rdata[4*DW +: DW], w1[l][d1_c[CW-1:0]]));
      end
    end
  end

  assign oc_clamp  = (int'(out_ch) > LANES) ? 8'(LANES) : ((out_ch == 8'd0) ? 8'd1 : out_ch);
  assign cand_last = (c == in_ch_q - 8'd1);
  assign stall     = cand_last && ((hold_cnt != 8'd0) || (imap_ren && rd_last) || (d1_vld && d1_last));
  assign drain_ok  = !imap_ren && !d1_vld && ((hold_cnt == 8'd0) || (hold_cnt == 8'd1 && out_rdy));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE; busy <= 1'b0; conv_done <= 1'b0; imap_ren <= 1'b0; imap_raddr <= '0;
      in_ch_q <= '0; oc_q <= '0; map_q <= '0; c <= '0; p <= '0; addr <= '0;
      rd_c <= '0; rd_p <= '0; rd_last <= 1'b0; d1_vld <= 1'b0; d1_c <= '0; d1_p <= '0; d1_last <= 1'b0;
      hold_cnt <= '0; hold_idx <= '0; hold_pix <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc3[l] <= '0; acc1[l] <= '0; hold3[l] <= '0; hold1[l] <= '0;
      end
    end else begin
      d1_vld <= imap_ren; d1_c <= rd_c; d1_p <= rd_p; d1_last <= rd_last;
      if (d1_vld) begin
        for (int l = 0; l < LANES; l++) begin
          if (d1_last) begin
            hold3[l] <= acc3[l] + c3[l]; hold1[l] <= acc1[l] + c1[l];
            acc3[l]  <= '0;              acc1[l]  <= '0;
          end else begin
            acc3[l] <= acc3[l] + c3[l];  acc1[l] <= acc1[l] + c1[l];
          end
        end
      end
      // The stall rule guarantees the hold buffer is empty whenever a pixel completes.
      if (d1_vld && d1_last) begin
        hold_cnt <= oc_q; hold_idx <= '0; hold_pix <= d1_p;
      end else if (out_vld && out_rdy) begin
        hold_cnt <= hold_cnt - 8'd1; hold_idx <= hold_idx + 8'd1;
      end
      case (state)
        IDLE: begin
          imap_ren <= 1'b0;
          if (conv_start) begin
            busy <= 1'b1; in_ch_q <= in_ch; map_q <= map_size; oc_q <= oc_clamp;
            if (in_ch == 8'd0 || map_size == 16'd0) begin
              state <= DONE;
            end else begin
              imap_ren <= 1'b1; imap_raddr <= '0; addr <= 32'd1;
              rd_c <= '0; rd_p <= '0; rd_last <= (in_ch == 8'd1);
              if (in_ch == 8'd1) begin
                c <= '0; p <= 16'd1;
                state <= (map_size == 16'd1) ? DRAIN : RUN;
              end else begin
                c <= 8'd1; p <= '0; state <= RUN;
              end
            end
          end
        end
        RUN: begin
          if (stall) begin
            imap_ren <= 1'b0;
          end else begin
            imap_ren <= 1'b1; imap_raddr <= addr; addr <= addr + 32'd1;
            rd_c <= c; rd_p <= p; rd_last <= cand_last;
            if (cand_last) begin
              c <= '0; p <= p + 16'd1;
              if (p == map_q - 16'd1) state <= DRAIN;
            end else begin
              c <= c + 8'd1;
            end
          end
        end
        DRAIN: begin
          imap_ren <= 1'b0;
          if (drain_ok) begin
            state <= DONE; conv_done <= 1'b1; busy <= 1'b0;
          end
        end
        DONE: begin
          if (!conv_done) begin
            conv_done <= 1'b1; busy <= 1'b0;
          end else begin
            conv_done <= 1'b0; state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MAC_ARRAY_GRP_IDENTITY_EN
  logic [7:0] id_acc [LANES];
  logic [7:0] hold_id [LANES];
  logic [7:0] x8;
  assign x8 = 8'($signed(imap_rdata[4*DW +: DW]));

  // Lane l keeps the centre pixel of input channel l; lanes beyond in_ch stay 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int l = 0; l < LANES; l++) begin
        id_acc[l] <= '0; hold_id[l] <= '0;
      end
    end else if (d1_vld) begin
      for (int l = 0; l < LANES; l++) begin
        if (d1_last) begin
          hold_id[l] <= (int'(d1_c) == l) ? x8 : id_acc[l];
          id_acc[l]  <= '0;
        end else if (int'(d1_c) == l) begin
          id_acc[l] <= x8;
        end
      end
    end
  end
  assign ident = hold_id[hold_idx[LW-1:0]];
`else
  assign ident = 8'd0;
`endif

  assign out_vld  = (hold_cnt != 8'd0);
  assign out_lane = hold_idx;
  assign out_pix  = hold_pix;
  assign out_data = out_vld ? {ident, hold1[hold_idx[LW-1:0]], hold3[hold_idx[LW-1:0]]} : '0;

endmodule

// File: tb/tb_mac_array_grp.sv
// tb/tb_mac_array_grp.sv - randomized self-checking bench for mac_array_grp against a behavioural model.
module tb_mac_array_grp;
  localparam int LANES = 8, DW = 8, ACC_W = 32, ACC1_W = 24, MAX_IN_CH = 64, OW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, conv_start, busy, conv_done, weight_wen, imap_ren, out_vld, out_rdy;
  logic [7:0] in_ch, out_ch, out_lane;
  logic [15:0] map_size, out_pix;
  logic [31:0] weight_waddr, imap_raddr;
  logic [10*DW-1:0] weight_wdata;
  logic [9*DW-1:0] imap_rdata;
  logic [OW-1:0] out_data;

  mac_array_grp #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .ACC1_W(ACC1_W), .MAX_IN_CH(MAX_IN_CH)) dut (
    .clk(clk), .rst_n(rst_n), .conv_start(conv_start), .in_ch(in_ch), .out_ch(out_ch),
    .map_size(map_size), .busy(busy), .conv_done(conv_done), .weight_waddr(weight_waddr),
    .weight_wdata(weight_wdata), .weight_wen(weight_wen), .imap_raddr(imap_raddr),
    .imap_ren(imap_ren), .imap_rdata(imap_rdata), .out_data(out_data), .out_pix(out_pix),
    .out_lane(out_lane), .out_vld(out_vld), .out_rdy(out_rdy));

  typedef struct { int pix; int lane; logic [OW-1:0] data; } exp_t;
  exp_t exp_q[$];
  logic [OW-1:0] cap_q[$];
  logic [9*DW-1:0] mem [0:1023];
  int w3m [LANES][MAX_IN_CH][9];
  int w1m [LANES][MAX_IN_CH];
  int checks = 0, errors = 0, reads = 0, done_cnt = 0, rdy_mode = 0, stall_reads = 0;
  logic pend_v;
  logic [31:0] pend_a;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // imap buffer: data valid exactly one cycle after imap_ren, garbage otherwise
  initial forever begin
    logic [95:0] junk;
    @(negedge clk);
    pend_v = imap_ren;
    pend_a = imap_raddr;
    @(posedge clk);
    #1;
    junk = {$urandom, $urandom, $urandom};
    imap_rdata = (pend_v && pend_a < 1024) ? mem[pend_a[9:0]] : junk[71:0];
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_rdy = 1'b1;
      1: out_rdy = 1'($urandom_range(0, 1));
      default: out_rdy = 1'b0;
    endcase
  end

  // Single compare process against the expected-output queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (imap_ren) begin
        chk("raddr", imap_raddr, reads);
        reads++;
      end
      if (conv_done) done_cnt++;
      if (out_vld) begin
        if (exp_q.size() == 0) chk("out_unexpected", out_vld, 0);
        else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_pix", out_pix, exp_q[0].pix);
          chk("out_lane", out_lane, exp_q[0].lane);
          if (out_rdy) begin
            void'(exp_q.pop_front());
            cap_q.push_back(out_data);
          end
        end
      end
    end
  end

  task automatic wr_w(input int ch, input int ln, input logic [79:0] d);
    weight_waddr = {16'd0, 8'(ch), 8'(ln)};
    weight_wdata = d;
    weight_wen = 1'b1;
    if (!busy && ch < MAX_IN_CH && ln < LANES) begin
      for (int k = 0; k < 9; k++) w3m[ln][ch][k] = int'($signed(d[k*8 +: 8]));
      w1m[ln][ch] = int'($signed(d[79:72]));
    end
    @(posedge clk);
    #1;
    weight_wen = 1'b0;
  endtask

  task automatic rand_setup(input int ic, input int ms);
    logic [95:0] r;
    for (int ch = 0; ch < ic; ch++)
      for (int l = 0; l < LANES; l++) begin
        r = {$urandom, $urandom, $urandom};
        wr_w(ch, l, r[79:0]);
      end
    for (int a = 0; a < ic * ms; a++) begin
      r = {$urandom, $urandom, $urandom};
      mem[a] = r[71:0];
    end
  endtask

  // Model: each output = sum over channels of the spec's per-word contributions, wrapped to the field width
  task automatic build_expected(input int ic, input int ocr, input int ms);
    int oc;
    longint s3, s1;
    logic [63:0] t3, t1;
    logic [7:0] id;
    logic [71:0] wd;
    exp_t e;
    oc = (ocr > LANES) ? LANES : ((ocr == 0) ? 1 : ocr);
    for (int p = 0; p < ms; p++)
      for (int l = 0; l < oc; l++) begin
        s3 = 0; s1 = 0; id = 8'd0;
        for (int ch = 0; ch < ic; ch++) begin
          wd = mem[p * ic + ch];
          if (ch < MAX_IN_CH) begin
            for (int k = 0; k < 9; k++) s3 += longint'($signed(wd[k*8 +: 8])) * w3m[l][ch][k];
            s1 += longint'($signed(wd[39:32])) * w1m[l][ch];
          end
`ifdef MAC_ARRAY_GRP_IDENTITY_EN
          if (ch == l) id = wd[39:32];
`endif
        end
        t3 = s3; t1 = s1;
        e.pix = p; e.lane = l; e.data = {id, t1[23:0], t3[31:0]};
        exp_q.push_back(e);
      end
  endtask

  task automatic start_pulse(input int ic, input int ocr, input int ms);
    exp_q.delete(); cap_q.delete(); reads = 0; done_cnt = 0;
    build_expected(ic, ocr, ms);
    in_ch = 8'(ic); out_ch = 8'(ocr); map_size = 16'(ms); conv_start = 1'b1;
    @(posedge clk);
    #1;
    conv_start = 1'b0;
  endtask

  task automatic run(input int ic, input int ocr, input int ms, input int mode, input int hold0);
    rdy_mode = (hold0 > 0) ? 2 : mode;
    start_pulse(ic, ocr, ms);
    if (ic != 0 && ms != 0) chk("first_ren", imap_ren, 1);
    chk("busy_run", busy, 1);
    for (int cyc = 0; cyc < 4000 && done_cnt == 0; cyc++) begin
      @(posedge clk);
      #1;
      if (hold0 > 0 && cyc == hold0 - 1) begin
        stall_reads = reads;
        chk("stall_vld", out_vld, 1);
        rdy_mode = mode;
      end
    end
    chk("done_seen", done_cnt > 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("exp_left", exp_q.size(), 0);
    chk("reads", reads, ic * ms);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    logic [63:0] d;
    logic [95:0] r;
    rst_n = 1'b0; conv_start = 1'b0; in_ch = '0; out_ch = '0; map_size = '0;
    weight_waddr = '0; weight_wdata = '0; weight_wen = 1'b0; imap_rdata = '0; out_rdy = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", conv_done, 0); chk("rst_ren", imap_ren, 0);
    chk("rst_vld", out_vld, 0); chk("rst_raddr", imap_raddr, 0); chk("rst_data", out_data, 0);
    chk("rst_pix", out_pix, 0); chk("rst_lane", out_lane, 0);
    rst_n = 1'b1;

    // Basic: taps 1, 1x1 weight 2, pixels 3
    for (int ch = 0; ch < 2; ch++)
      for (int l = 0; l < LANES; l++) wr_w(ch, l, {8'd2, {9{8'd1}}});
    mem[0] = {9{8'd3}}; mem[1] = {9{8'd3}};
    run(2, 8, 1, 0, 0);
    chk("t1_count", cap_q.size(), 8);
    d = cap_q[0];
    chk("t1_l0_3x3", d[31:0], 54); chk("t1_l0_1x1", d[55:32], 12);
`ifdef MAC_ARRAY_GRP_IDENTITY_EN
    chk("t1_l0_id", d[63:56], 3);
`else
    chk("t1_l0_id", d[63:56], 0);
`endif
    d = cap_q[7];
    chk("t1_l7_3x3", d[31:0], 54); chk("t1_l7_id", d[63:56], 0);

    // Backpressure with single-channel pixels
    rand_setup(1, 4);
    run(1, 3, 4, 0, 20);
    chk("stall_reads_le2", stall_reads <= 2, 1);

    // Signed extremes
    for (int ch = 0; ch < 64; ch++)
      for (int l = 0; l < LANES; l++) wr_w(ch, l, {10{8'h80}});
    for (int a = 0; a < 64; a++) mem[a] = {9{8'h80}};
    run(64, 8, 1, 1, 0);
    d = cap_q[0];
    chk("wrap_3x3", d[31:0], 9437184); chk("wrap_1x1", d[55:32], 1048576);

    // Empty runs
    rdy_mode = 0;
    start_pulse(0, 8, 5);
    chk("ic0_done_early", conv_done, 0); chk("ic0_ren", imap_ren, 0);
    @(posedge clk);
    #1;
    chk("ic0_done", conv_done, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("ic0_reads", reads, 0);
    run(3, 8, 0, 0, 0);

    // Reset mid-drain with a pending output
    rand_setup(2, 1);
    rdy_mode = 2;
    start_pulse(2, 4, 1);
    for (int cyc = 0; cyc < 100 && !(reads == 2 && out_vld); cyc++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_reached", reads == 2 && out_vld, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_vld", out_vld, 0); chk("mid_rst_data", out_data, 0); chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ren", imap_ren, 0); chk("mid_rst_pix", out_pix, 0); chk("mid_rst_raddr", imap_raddr, 0);
    exp_q.delete();
    rst_n = 1'b1;
    run(2, 8, 2, 1, 0);

    // Dropped out-of-range writes, then writes during busy
    rand_setup(2, 3);
    wr_w(64, 0, '1); wr_w(0, 8, '1); wr_w(255, 255, '1);
    fork
      run(2, 12, 3, 1, 0);
      begin
        @(posedge clk);
        #1;
        r = {$urandom, $urandom, $urandom};
        chk("busy_write_busy", busy, 1);
        wr_w(0, 0, r[79:0]);
        wr_w(1, 3, ~r[79:0]);
      end
    join

    for (int t = 0; t < 6; t++) begin
      int ic, ocr, ms;
      ic = $urandom_range(1, 4); ocr = $urandom_range(1, 12); ms = $urandom_range(1, 5);
      rand_setup(ic, ms);
      run(ic, ocr, ms, 1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
